// File: rtl/retire_stage_pkg.sv
// Shared types and constants for the in-order retire stage.
package retire_stage_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned ROB_TAG_LEN = 4;
  localparam int unsigned REG_IDX_W   = 5;
  localparam int unsigned MEM_SIZE_W  = 3;

  typedef logic [31:0] INST;

  localparam logic [REG_IDX_W-1:0] ZERO_REG = 5'd0;
  localparam INST                  WFI_INST = 32'h1050_0073;

  typedef struct packed {
    logic                  valid;
    logic [XLEN-1:0]       NPC;
    INST                   inst;
    logic                  wr_mem;
    logic [REG_IDX_W-1:0]  dest_reg;
    logic [XLEN-1:0]       dest_addr;
    logic [XLEN-1:0]       value;
    logic [MEM_SIZE_W-1:0] mem_size;
    logic                  value_ready;
    logic                  address_ready;
  } ROB_ENTRY;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ST_WAIT = 2'd1,
    HALTED  = 2'd2
  } retire_state_e;

endpackage

// File: rtl/retire_stage.sv
// Retires the ROB head: register writeback and map-table clear for ALU ops,
// a held store handshake for memory writes, and a sticky halt on WFI.
module retire_stage
  import retire_stage_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  ROB_ENTRY               head_entry,
  input  logic [ROB_TAG_LEN-1:0] head_tag,
  input  logic                   head_ready,
  output logic                   retire_en,
  output logic                   rf_wr_en,
  output logic [REG_IDX_W-1:0]   rf_wr_idx,
  output logic [XLEN-1:0]        rf_wr_data,
  output logic                   mt_clr_valid,
  output logic [REG_IDX_W-1:0]   mt_clr_reg,
  output logic [ROB_TAG_LEN-1:0] mt_clr_tag,
  output logic                   mem_req,
  output logic [XLEN-1:0]        mem_addr,
  output logic [XLEN-1:0]        mem_data,
  output logic [MEM_SIZE_W-1:0]  mem_size,
  input  logic                   mem_ack,
  output logic                   halted,
  output logic [63:0]            retired_count,
  output logic [31:0]            store_count
);

  retire_state_e state_q, state_d;
  logic          latch_store;
  logic          store_done;
  logic          head_go;

  // Readiness is carried by head_ready; these per-field flags are informational only.
  logic unused_fields;
  assign unused_fields = ^{head_entry.NPC, head_entry.value_ready, head_entry.address_ready};

  assign head_go = head_entry.valid && head_ready;

  always_comb begin
    state_d      = state_q;
    retire_en    = 1'b0;
    rf_wr_en     = 1'b0;
    rf_wr_idx    = ZERO_REG;
    rf_wr_data   = '0;
    mt_clr_valid = 1'b0;
    mt_clr_reg   = ZERO_REG;
    mt_clr_tag   = '0;
    latch_store  = 1'b0;
    store_done   = 1'b0;
    if (!reset) begin
      unique case (state_q)
        IDLE: begin
          if (head_go) begin
            if (head_entry.inst == WFI_INST) begin
              retire_en = 1'b1;
              state_d   = HALTED;
            end else if (head_entry.wr_mem) begin
              latch_store = 1'b1;
              state_d     = ST_WAIT;
            end else begin
              retire_en    = 1'b1;
              rf_wr_en     = (head_entry.dest_reg != ZERO_REG);
              rf_wr_idx    = head_entry.dest_reg;
              rf_wr_data   = head_entry.value;
              mt_clr_valid = (head_entry.dest_reg != ZERO_REG);
              mt_clr_reg   = head_entry.dest_reg;
              mt_clr_tag   = head_tag;
            end
          end
        end
        ST_WAIT: begin
          // Head contents are ignored here; the store runs on the registered payload.
          if (mem_ack) begin
            retire_en  = 1'b1;
            store_done = 1'b1;
            state_d    = IDLE;
          end
        end
        HALTED: begin
          state_d = HALTED;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      mem_req       <= 1'b0;
      mem_addr      <= '0;
      mem_data      <= '0;
      mem_size      <= '0;
      halted        <= 1'b0;
      retired_count <= '0;
      store_count   <= '0;
    end else begin
      state_q <= state_d;
      halted  <= (state_d == HALTED);
      if (latch_store) begin
        mem_req  <= 1'b1;
        mem_addr <= head_entry.dest_addr;
        mem_data <= head_entry.value;
        mem_size <= head_entry.mem_size;
      end
      if (store_done) begin
        mem_req     <= 1'b0;
        store_count <= store_count + 32'd1;
      end
      if (retire_en) begin
        retired_count <= retired_count + 64'd1;
      end
    end
  end

endmodule

// File: tb/tb_retire_stage.sv
// Directed bench for retire_stage: ALU/x0 retires, store handshake, reset in
// ST_WAIT, and WFI halt, with hand-computed expectations.
module tb_retire_stage;
  import retire_stage_pkg::*;

  logic                   clock = 1'b0;
  logic                   reset;
  ROB_ENTRY               head_entry;
  logic [ROB_TAG_LEN-1:0] head_tag;
  logic                   head_ready;
  logic                   retire_en;
  logic                   rf_wr_en;
  logic [REG_IDX_W-1:0]   rf_wr_idx;
  logic [XLEN-1:0]        rf_wr_data;
  logic                   mt_clr_valid;
  logic [REG_IDX_W-1:0]   mt_clr_reg;
  logic [ROB_TAG_LEN-1:0] mt_clr_tag;
  logic                   mem_req;
  logic [XLEN-1:0]        mem_addr;
  logic [XLEN-1:0]        mem_data;
  logic [MEM_SIZE_W-1:0]  mem_size;
  logic                   mem_ack;
  logic                   halted;
  logic [63:0]            retired_count;
  logic [31:0]            store_count;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  retire_stage dut (
    .clock        (clock),
    .reset        (reset),
    .head_entry   (head_entry),
    .head_tag     (head_tag),
    .head_ready   (head_ready),
    .retire_en    (retire_en),
    .rf_wr_en     (rf_wr_en),
    .rf_wr_idx    (rf_wr_idx),
    .rf_wr_data   (rf_wr_data),
    .mt_clr_valid (mt_clr_valid),
    .mt_clr_reg   (mt_clr_reg),
    .mt_clr_tag   (mt_clr_tag),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .mem_size     (mem_size),
    .mem_ack      (mem_ack),
    .halted       (halted),
    .retired_count(retired_count),
    .store_count  (store_count)
  );

  function automatic ROB_ENTRY mk(input logic valid, input INST inst, input logic wr_mem,
                                  input logic [4:0] dest_reg, input logic [31:0] addr,
                                  input logic [31:0] value, input logic [2:0] size);
    ROB_ENTRY e;
    e = '0;
    e.valid         = valid;
    e.NPC           = 32'h0000_1004;
    e.inst          = inst;
    e.wr_mem        = wr_mem;
    e.dest_reg      = dest_reg;
    e.dest_addr     = addr;
    e.value         = value;
    e.mem_size      = size;
    e.value_ready   = 1'b1;
    e.address_ready = 1'b1;
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge; inputs change there, outputs settle by #1.
  task automatic step();
    @(negedge clock);
  endtask

  localparam INST ALU_OP = 32'h0000_0033;
  localparam INST ST_OP  = 32'h0000_2023;

  initial begin
    reset      = 1'b1;
    mem_ack    = 1'b0;
    head_tag   = 4'd3;
    head_ready = 1'b1;
    head_entry = mk(1'b1, ALU_OP, 1'b0, 5'd5, 32'h0, 32'hDEAD_BEEF, 3'd0);

    // Reset: combinational outputs forced low even with a ready head
    step(); #1;
    check("rst_retire_en", 64'(retire_en), 64'd0);
    check("rst_rf_wr_en", 64'(rf_wr_en), 64'd0);
    check("rst_mt_clr_valid", 64'(mt_clr_valid), 64'd0);
    step(); #1;
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_retired_count", retired_count, 64'd0);
    check("rst_store_count", 64'(store_count), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);

    // ALU retire to r5
    step(); reset = 1'b0; #1;
    check("alu_retire_en", 64'(retire_en), 64'd1);
    check("alu_rf_wr_en", 64'(rf_wr_en), 64'd1);
    check("alu_rf_wr_idx", 64'(rf_wr_idx), 64'd5);
    check("alu_rf_wr_data", 64'(rf_wr_data), 64'hDEAD_BEEF);
    check("alu_mt_clr_valid", 64'(mt_clr_valid), 64'd1);
    check("alu_mt_clr_reg", 64'(mt_clr_reg), 64'd5);
    check("alu_mt_clr_tag", 64'(mt_clr_tag), 64'd3);
    check("alu_count_before", retired_count, 64'd0);

    // x0 destination: retires without writeback
    step();
    head_entry = mk(1'b1, ALU_OP, 1'b0, 5'd0, 32'h0, 32'd7, 3'd0);
    #1;
    check("alu_count_after", retired_count, 64'd1);
    check("x0_retire_en", 64'(retire_en), 64'd1);
    check("x0_rf_wr_en", 64'(rf_wr_en), 64'd0);
    check("x0_mt_clr_valid", 64'(mt_clr_valid), 64'd0);

    // Valid head but not ready: nothing retires
    step();
    head_entry = mk(1'b1, ALU_OP, 1'b0, 5'd6, 32'h0, 32'd1, 3'd0);
    head_ready = 1'b0;
    #1;
    check("x0_count_after", retired_count, 64'd2);
    check("notready_retire_en", 64'(retire_en), 64'd0);
    check("notready_rf_wr_en", 64'(rf_wr_en), 64'd0);

    // Store: ready at cycle 0
    step();
    head_ready = 1'b1;
    head_entry = mk(1'b1, ST_OP, 1'b1, 5'd0, 32'h100, 32'h55, 3'd2);
    #1;
    check("notready_count", retired_count, 64'd2);
    check("st0_retire_en", 64'(retire_en), 64'd0);
    check("st0_mem_req", 64'(mem_req), 64'd0);

    // Cycle 1: request up with payload; head now a ready ALU op that must wait
    step();
    head_entry = mk(1'b1, ALU_OP, 1'b0, 5'd9, 32'hFFFF_FFF0, 32'h1234, 3'd7);
    #1;
    check("st1_mem_req", 64'(mem_req), 64'd1);
    check("st1_mem_addr", 64'(mem_addr), 64'h100);
    check("st1_mem_data", 64'(mem_data), 64'h55);
    check("st1_mem_size", 64'(mem_size), 64'd2);
    check("st1_retire_en", 64'(retire_en), 64'd0);
    check("st1_rf_wr_en", 64'(rf_wr_en), 64'd0);

    // Cycle 2: still waiting, payload held
    step(); #1;
    check("st2_mem_req", 64'(mem_req), 64'd1);
    check("st2_mem_addr", 64'(mem_addr), 64'h100);
    check("st2_mem_data", 64'(mem_data), 64'h55);
    check("st2_retire_en", 64'(retire_en), 64'd0);

    // Cycle 3: ack -> store retires, no register write
    step(); mem_ack = 1'b1; #1;
    check("st3_retire_en", 64'(retire_en), 64'd1);
    check("st3_rf_wr_en", 64'(rf_wr_en), 64'd0);
    check("st3_mt_clr_valid", 64'(mt_clr_valid), 64'd0);
    check("st3_store_count", 64'(store_count), 64'd0);

    // Cycle 4: back in IDLE; waiting ALU op retires now
    step(); mem_ack = 1'b0; #1;
    check("st4_mem_req", 64'(mem_req), 64'd0);
    check("st4_store_count", 64'(store_count), 64'd1);
    check("st4_retired_count", retired_count, 64'd3);
    check("b2b_retire_en", 64'(retire_en), 64'd1);
    check("b2b_rf_wr_idx", 64'(rf_wr_idx), 64'd9);
    check("b2b_rf_wr_data", 64'(rf_wr_data), 64'h1234);

    // Stray ack in IDLE is ignored
    step();
    head_entry = mk(1'b0, ALU_OP, 1'b0, 5'd0, 32'h0, 32'h0, 3'd0);
    mem_ack = 1'b1;
    #1;
    check("b2b_retired_count", retired_count, 64'd4);
    check("stray_ack_retire_en", 64'(retire_en), 64'd0);
    step(); mem_ack = 1'b0; #1;
    check("stray_ack_store_count", 64'(store_count), 64'd1);
    check("stray_ack_mem_req", 64'(mem_req), 64'd0);
    check("stray_ack_retired_count", retired_count, 64'd4);

    // Reset while in ST_WAIT, coinciding with ack
    head_entry = mk(1'b1, ST_OP, 1'b1, 5'd0, 32'h200, 32'hAA, 3'd1);
    step();
    head_entry = mk(1'b0, ALU_OP, 1'b0, 5'd0, 32'h0, 32'h0, 3'd0);
    #1;
    check("rsw_mem_req_up", 64'(mem_req), 64'd1);
    check("rsw_mem_addr", 64'(mem_addr), 64'h200);
    step(); reset = 1'b1; mem_ack = 1'b1; #1;
    check("rsw_retire_en", 64'(retire_en), 64'd0);
    step(); reset = 1'b0; mem_ack = 1'b0; #1;
    check("rsw_mem_req", 64'(mem_req), 64'd0);
    check("rsw_retired_count", retired_count, 64'd0);
    check("rsw_store_count", 64'(store_count), 64'd0);
    check("rsw_mem_addr_clr", 64'(mem_addr), 64'd0);
    step();
    head_entry = mk(1'b1, ALU_OP, 1'b0, 5'd1, 32'h0, 32'h42, 3'd0);
    #1;
    check("rsw_idle_retire_en", 64'(retire_en), 64'd1);

    // WFI: one retire, then halted for good
    step();
    head_entry = mk(1'b1, WFI_INST, 1'b0, 5'd0, 32'h0, 32'h0, 3'd0);
    #1;
    check("wfi_retire_en", 64'(retire_en), 64'd1);
    check("wfi_halted_before", 64'(halted), 64'd0);
    step();
    head_entry = mk(1'b1, ALU_OP, 1'b0, 5'd4, 32'h0, 32'h9, 3'd0);
    #1;
    check("wfi_halted", 64'(halted), 64'd1);
    check("wfi_retired_count", retired_count, 64'd2);
    for (int i = 0; i < 12; i++) begin
      head_entry = mk(1'b1, (i % 2 == 0) ? ST_OP : ALU_OP, 1'(i % 2 == 0), 5'd4,
                      32'h300, 32'h9, 3'd2);
      mem_ack = 1'(i % 3 == 0);
      #1;
      check("halt_retire_en", 64'(retire_en), 64'd0);
      check("halt_rf_wr_en", 64'(rf_wr_en), 64'd0);
      check("halt_mt_clr_valid", 64'(mt_clr_valid), 64'd0);
      check("halt_mem_req", 64'(mem_req), 64'd0);
      check("halt_halted", 64'(halted), 64'd1);
      step();
    end
    mem_ack = 1'b0;
    #1;
    check("halt_retired_count", retired_count, 64'd2);
    check("halt_store_count", 64'(store_count), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/retire_stage.md
RETIRE_STAGE -- requirements
Module: retire_stage

Interface
REQ-001 SHALL have these ports (clock and reset first): clock input 1 (system clock); reset input 1 (reset, synchronous, active-high; clock clock).
REQ-002 SHALL have head_entry input ROB_ENTRY: ROB head slot, with fields valid, NPC, inst, wr_mem, dest_reg, dest_addr, value, mem_size, value_ready, address_ready.
REQ-003 SHALL have head_tag input ROB_TAG_LEN: tag of the head slot; head_ready input 1: head value and address are both ready.
REQ-004 SHALL have retire_en output 1: ROB pops its head this cycle. ROB head advance is gated by this signal, not by head_ready.
REQ-005 SHALL have rf_wr_en output 1, rf_wr_idx output 5 and rf_wr_data output XLEN: the register-file write port.
REQ-006 SHALL have mt_clr_valid output 1, mt_clr_reg output 5 and mt_clr_tag output ROB_TAG_LEN: map-table clear request. The map table clears the entry only if it still holds mt_clr_tag.
REQ-007 SHALL have these store-port signals: mem_req output 1, mem_addr output XLEN, mem_data output XLEN, mem_size output 3, and mem_ack input 1 (store accepted).
REQ-008 SHALL have halted output 1, retired_count output 64 and store_count output 32.

Function
REQ-009 FSM states: IDLE, ST_WAIT, HALTED.
REQ-010 IDLE, with head_entry.valid, head_ready and wr_mem=0:
- retire_en=1 combinationally in the same cycle.
- State remains IDLE.
REQ-011 In that same cycle, rf_wr_en=1 when dest_reg!=0, with rf_wr_idx=dest_reg and rf_wr_data=value. rf_wr_en=0 when dest_reg=0.
REQ-012 mt_clr_valid SHALL equal rf_wr_en, with mt_clr_reg=dest_reg and mt_clr_tag=head_tag.
REQ-013 IDLE, with a valid ready store (wr_mem=1):
- retire_en=0.
- Next cycle: state ST_WAIT, mem_req=1, and mem_addr/mem_data/mem_size registered from dest_addr/value/mem_size.
REQ-014 ST_WAIT: mem_req and the mem_* payload SHALL be held stable until mem_ack.
REQ-015 ST_WAIT with mem_ack=1:
- retire_en=1 in the same cycle.
- mem_req=0 and state IDLE next cycle.
- store_count increments.
- No rf/mt write for stores.
REQ-016 Minimum store retire latency is 2 cycles (ready to ack); at most one instruction retires per cycle.
REQ-017 IDLE with the head inst equal to 32'h10500073 (WFI), valid and ready: retire_en=1, then HALTED next cycle.
REQ-018 HALTED: halted=1, retire_en=0, mem_req=0 and no rf/mt writes until reset.
REQ-019 retired_count increments by 1 on every cycle where retire_en=1 (stores and WFI included). It wraps modulo 2^64.
REQ-020 head_entry.valid=0 or head_ready=0 in IDLE: retire_en, rf_wr_en, mt_clr_valid=0 and the state is unchanged.
REQ-021 In ST_WAIT, changes on head_entry SHALL be ignored; only the registered payload is used.
REQ-022 mem_ack outside ST_WAIT SHALL be ignored.
REQ-023 All outputs other than retire_en, rf_* and mt_* SHALL be registered.

Reset
REQ-024 Reset has priority over all events, including mem_ack in the same cycle.
REQ-025 Next-cycle values on reset: state IDLE; mem_req=0; mem_addr, mem_data, mem_size=0; halted=0; retired_count=0; store_count=0.
REQ-026 Reset asserted in ST_WAIT SHALL drop mem_req in the next cycle; no pop and no count change.
REQ-027 While reset is high, the combinational outputs retire_en, rf_wr_en and mt_clr_valid SHALL be 0.

Structure
REQ-028 The shared package SHALL hold: ROB_ENTRY, INST, XLEN, ROB_TAG_LEN, ZERO_REG, the WFI encoding constant and the retire FSM state enum.
REQ-029 SHALL be a single module with no sub-modules; the store handshake is natural as one always_ff plus one always_comb.

Verification
REQ-030 ALU retire: head valid/ready, dest_reg=5, value=32'hDEAD_BEEF, head_tag=3 -> same cycle retire_en=1, rf_wr_en=1 idx 5 data DEADBEEF, mt_clr tag 3; retired_count 0->1.
REQ-031 x0 destination: dest_reg=0, value=7 -> retire_en=1, rf_wr_en=0, mt_clr_valid=0, retired_count increments.
REQ-032 Store with 3-cycle ack: dest_addr=0x100, value=0x55, mem_size=2 -> mem_req=1 from cycle+1 with payload held; ack on cycle+3 -> retire_en=1 that cycle; mem_req=0 next cycle; store_count=1; no rf write.
REQ-033 Back-to-back: store then ALU op ready -> ALU retires the cycle after the store ack, never in the same cycle.
REQ-034 WFI at head, then further ready entries -> one retire, halted=1, retire_en stays 0 for 10+ cycles.
REQ-035 Reset in ST_WAIT, with mem_ack=1 in the same cycle -> no retire_en, mem_req=0 next cycle, counters 0, state IDLE.
